// File: rtl/ulpb_tx_queue_pkg.sv
// ulpb_tx_queue_pkg: shared ULPB definitions (ADDR_WIDTH/DATA_WIDTH macros, TX queue FSM states, retry limit)
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package ulpb_tx_queue_pkg;
  typedef enum logic [2:0] {TXQ_IDLE, TXQ_REQ, TXQ_REL, TXQ_RESP, TXQ_RACK} txq_state_t;
  localparam int RETRY_LIMIT = 3;
endpackage

// File: rtl/ulpb_sync2.sv
// ulpb_sync2: two-flop synchronizer with synchronous active-high reset
module ulpb_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) begin
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/ulpb_tx_queue.sv
// ulpb_tx_queue: message queue feeding the ULPB node TX handshake, reporting per-message verdicts.
// Define ULPB_TXQ_RETRY_EN to retransmit failed messages up to three times before reporting failure.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module ulpb_tx_queue
  import ulpb_tx_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_LAST,
  output logic                  MSG_DONE,
  output logic                  MSG_FAIL,
  output logic                  OVF_ERR,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_PEND,
  output logic                  TX_REQ,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_last [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, cmt_ptr, msg_cnt;
  logic [AW-1:0] rd_idx;
  logic drop, fail_q, ack_s, succ_s, fail_s;
  logic full, wr_fire, ovf, load, resp_clr, rack_exit, retry, commit;
  txq_state_t state, state_nx;
  ulpb_sync2 u_sync_ack  (.clk(CLK), .rst(RESET), .d(TX_ACK),  .q(ack_s));
  ulpb_sync2 u_sync_succ (.clk(CLK), .rst(RESET), .d(TX_SUCC), .q(succ_s));
  ulpb_sync2 u_sync_fail (.clk(CLK), .rst(RESET), .d(TX_FAIL), .q(fail_s));
  // the in-flight message keeps its entries until commit, so occupancy is measured from cmt_ptr
  assign full      = (wr_ptr[AW] != cmt_ptr[AW]) && (wr_ptr[AW-1:0] == cmt_ptr[AW-1:0]);
  assign WR_READY  = ~RESET & ~full;
  assign wr_fire   = WR_VALID & WR_READY;
  assign ovf       = full & (msg_cnt == '0) & ~drop;
  assign rd_idx    = rd_ptr[AW-1:0];
  assign resp_clr  = ~succ_s & ~fail_s;
  assign rack_exit = (state == TXQ_RACK) & resp_clr & ~RESET;
  assign commit    = rack_exit & ~retry;
  assign MSG_DONE  = commit;
  assign MSG_FAIL  = commit & fail_q;
  assign TX_REQ      = state == TXQ_REQ;
  assign TX_RESP_ACK = state == TXQ_RACK;
`ifdef ULPB_TXQ_RETRY_EN
  logic [1:0] retry_cnt;
  assign retry = fail_q & (retry_cnt != 2'(RETRY_LIMIT));
  always_ff @(posedge CLK) begin
    if (RESET || commit) retry_cnt <= '0;
    else if (rack_exit) retry_cnt <= retry_cnt + 2'd1;
  end
`else
  assign retry = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      TXQ_IDLE: if (msg_cnt != '0) state_nx = TXQ_REQ;
      TXQ_REQ:  if (ack_s) state_nx = TXQ_REL;
      TXQ_REL:  if (!ack_s) state_nx = TX_PEND ? TXQ_REQ : TXQ_RESP;
      TXQ_RESP: if (succ_s | fail_s) state_nx = TXQ_RACK;
      TXQ_RACK: if (resp_clr) state_nx = TXQ_IDLE;
      default:  state_nx = TXQ_IDLE;
    endcase
  end
  assign load = (state == TXQ_IDLE || state == TXQ_REL) && state_nx == TXQ_REQ;
  always_ff @(posedge CLK) begin
    if (wr_fire && !drop) begin
      mem_addr[wr_ptr[AW-1:0]] <= WR_ADDR;
      mem_data[wr_ptr[AW-1:0]] <= WR_DATA;
      mem_last[wr_ptr[AW-1:0]] <= WR_LAST;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= TXQ_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cmt_ptr <= '0;
      msg_cnt <= '0;
      drop    <= 1'b0;
      fail_q  <= 1'b0;
      OVF_ERR <= 1'b0;
      TX_ADDR <= '0;
      TX_DATA <= '0;
      TX_PEND <= 1'b0;
    end else begin
      state   <= state_nx;
      OVF_ERR <= ovf;
      if (ovf) begin
        wr_ptr <= cmt_ptr;
        drop   <= 1'b1;
      end else if (wr_fire) begin
        if (drop) drop <= ~WR_LAST;
        else wr_ptr <= wr_ptr + PTR_ONE;
      end
      msg_cnt <= msg_cnt + {{AW{1'b0}}, wr_fire & WR_LAST & ~drop} - {{AW{1'b0}}, commit};
      // the address of a message is taken from its first word only
      if (load && state == TXQ_IDLE) TX_ADDR <= mem_addr[rd_idx];
      if (load) begin
        TX_DATA <= mem_data[rd_idx];
        TX_PEND <= ~mem_last[rd_idx];
      end
      if (state == TXQ_REQ && ack_s) rd_ptr <= rd_ptr + PTR_ONE;
      else if (rack_exit && retry) rd_ptr <= cmt_ptr;
      if (state == TXQ_RESP && (succ_s || fail_s)) fail_q <= fail_s;
      if (commit) cmt_ptr <= rd_ptr;
    end
  end
endmodule

// File: tb/tb_ulpb_tx_queue.sv
// tb_ulpb_tx_queue: randomized bench for ulpb_tx_queue against a message-level model of queue and node
module tb_ulpb_tx_queue;
  localparam int DEPTH = 8;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef ULPB_TXQ_RETRY_EN
  localparam int MAX_TRIES = 4;
`else
  localparam int MAX_TRIES = 1;
`endif
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic WR_VALID = 1'b0, WR_LAST = 1'b0;
  logic [AW-1:0] WR_ADDR = '0;
  logic [DW-1:0] WR_DATA = '0;
  logic WR_READY, MSG_DONE, MSG_FAIL, OVF_ERR, TX_PEND, TX_REQ, TX_RESP_ACK;
  logic [AW-1:0] TX_ADDR;
  logic [DW-1:0] TX_DATA;
  logic node_en = 1'b0, node_ack = 1'b0, node_succ = 1'b0, node_fail = 1'b0;
  logic man_ack = 1'b0, man_succ = 1'b0, man_fail = 1'b0;
  wire TX_ACK  = node_en ? node_ack  : man_ack;
  wire TX_SUCC = node_en ? node_succ : man_succ;
  wire TX_FAIL = node_en ? node_fail : man_fail;
  int checks = 0, errors = 0, cyc = 0;
  int fail_mode = 2;
  int ovf_exp = 0, ovf_seen = 0, req_rises = 0, tx_count = 0;
  logic last_fail = 1'b0;
  logic [AW-1:0] msg_addr[$];
  int msg_len[$];
  logic [DW-1:0] data_q[$];
  logic done_q[$];
  logic pend_log[$];

  ulpb_tx_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RESET(RESET), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .WR_LAST(WR_LAST), .MSG_DONE(MSG_DONE), .MSG_FAIL(MSG_FAIL),
    .OVF_ERR(OVF_ERR), .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND),
    .TX_REQ(TX_REQ), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
    .TX_RESP_ACK(TX_RESP_ACK)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic sig(input int s);
    return s == 0 ? TX_REQ : s == 1 ? TX_RESP_ACK : MSG_DONE;
  endfunction

  task automatic wait_sig(input int s, input logic v, input string name);
    int n = 0;
    while (sig(s) !== v && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_reached"}, n < 200, 1);
  endtask

  task automatic write_raw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    int n = 0;
    logic acc;
    WR_VALID = 1'b1; WR_ADDR = a; WR_DATA = d; WR_LAST = l;
    do begin
      acc = WR_READY;
      @(negedge CLK);
      n++;
    end while (!acc && n < 3000);
    WR_VALID = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL write_accept got=stalled expected=accepted data=%0h", d);
    end
  endtask

  task automatic write_msg(input int len);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom);
    if (len <= DEPTH) begin
      msg_addr.push_back(a);
      msg_len.push_back(len);
    end else ovf_exp++;
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      if (len <= DEPTH) data_q.push_back(d);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      write_raw(i == 0 ? a : AW'($urandom), d, i == len - 1);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((msg_len.size() != 0 || done_q.size() != 0) && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    repeat (5) @(negedge CLK);
    chk({name, "_drain"}, n < 20000, 1);
  endtask

  // node model: four-phase handshake per word, verdict per message, retransmission bookkeeping
  initial begin : node
    int w, tries, ack_fall;
    logic f;
    w = 0; tries = 0; ack_fall = -10;
    forever begin
      @(negedge CLK);
      if (node_en && TX_REQ && !node_ack) begin
        chk("req_gap", cyc - ack_fall >= 3, 1);
        if (msg_len.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req got addr=%0h data=%0h expected=no request", TX_ADDR, TX_DATA);
        end else begin
          chk("tx_addr", TX_ADDR, msg_addr[0]);
          chk("tx_data", TX_DATA, data_q[w]);
          chk("tx_pend", TX_PEND, w != msg_len[0] - 1);
        end
        pend_log.push_back(TX_PEND);
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        node_ack = 1'b1;
        while (TX_REQ) @(negedge CLK);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        node_ack = 1'b0;
        ack_fall = cyc;
        if (msg_len.size() != 0 && w == msg_len[0] - 1) begin
          f = fail_mode == 1 || (fail_mode == 0 && $urandom_range(0, 3) == 0);
          node_fail = f;
          node_succ = !f || ($urandom_range(0, 3) == 0);
          tries++;
          tx_count++;
          while (!TX_RESP_ACK) @(negedge CLK);
          repeat ($urandom_range(0, 3)) begin
            @(negedge CLK);
            chk("resp_ack_hold", TX_RESP_ACK, 1);
          end
          if (!f || tries == MAX_TRIES) begin
            done_q.push_back(f);
            repeat (msg_len[0]) void'(data_q.pop_front());
            void'(msg_len.pop_front());
            void'(msg_addr.pop_front());
            tries = 0;
          end
          w = 0;
          node_succ = 1'b0;
          node_fail = 1'b0;
        end else w++;
      end
    end
  end

  // compare process: verdict reports, overflow pulses and TX stability while requesting
  logic prev_req = 1'b0, prev_pend = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge CLK) begin
    if (MSG_DONE) begin
      last_fail = MSG_FAIL;
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL msg_done got=pulse fail=%0b expected=none", MSG_FAIL);
      end else chk("msg_fail", MSG_FAIL, done_q.pop_front());
    end else if (MSG_FAIL) begin
      checks++; errors++;
      $display("FAIL msg_fail_alone got=1 expected=0");
    end
    if (OVF_ERR) ovf_seen++;
    if (TX_REQ && !prev_req) req_rises++;
    if (TX_REQ && prev_req)
      chk("tx_stable", {TX_PEND, TX_ADDR, TX_DATA}, {prev_pend, prev_addr, prev_data});
    prev_req = TX_REQ; prev_pend = TX_PEND; prev_addr = TX_ADDR; prev_data = TX_DATA;
  end

  initial begin
    int r0, t0, len;
    repeat (3) @(negedge CLK);
    chk("rst_wr_ready", WR_READY, 0);
    chk("rst_msg_done", MSG_DONE, 0);
    chk("rst_msg_fail", MSG_FAIL, 0);
    chk("rst_ovf_err", OVF_ERR, 0);
    chk("rst_tx_req", TX_REQ, 0);
    chk("rst_tx_pend", TX_PEND, 0);
    chk("rst_resp_ack", TX_RESP_ACK, 0);
    chk("rst_tx_addr", TX_ADDR, 0);
    chk("rst_tx_data", TX_DATA, 0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", WR_READY, 1);
    // single word, node driven by hand for exact latencies
    write_raw(8'h5A, 32'hDEADBEEF, 1'b1);
    chk("req_lat_n1", TX_REQ, 0);
    @(negedge CLK);
    chk("req_lat_n2", TX_REQ, 1);
    chk("single_addr", TX_ADDR, 8'h5A);
    chk("single_data", TX_DATA, 32'hDEADBEEF);
    chk("single_pend", TX_PEND, 0);
    man_ack = 1'b1;
    repeat (2) @(negedge CLK);
    chk("req_held_after_ack", TX_REQ, 1);
    @(negedge CLK);
    chk("req_fall_3cyc", TX_REQ, 0);
    man_ack = 1'b0;
    man_succ = 1'b1;
    done_q.push_back(1'b0);
    wait_sig(1, 1'b1, "resp_ack_rise");
    repeat (3) begin
      @(negedge CLK);
      chk("single_resp_hold", TX_RESP_ACK, 1);
    end
    man_succ = 1'b0;
    wait_sig(2, 1'b1, "single_done");
    chk("single_fail_flag", MSG_FAIL, 0);
    @(negedge CLK);
    chk("resp_ack_drop", TX_RESP_ACK, 0);
    chk("done_one_cycle", MSG_DONE, 0);
    // three words, later addresses ignored, no request before LAST
    node_en = 1'b1;
    fail_mode = 2;
    pend_log.delete();
    msg_addr.push_back(8'h33); msg_len.push_back(3);
    data_q.push_back(32'h1); data_q.push_back(32'h2); data_q.push_back(32'h3);
    write_raw(8'h33, 32'h1, 1'b0);
    write_raw(8'h77, 32'h2, 1'b0);
    repeat (6) begin
      @(negedge CLK);
      chk("no_req_before_last", TX_REQ, 0);
    end
    write_raw(8'h11, 32'h3, 1'b1);
    drain("three");
    chk("pend_count", pend_log.size(), 3);
    if (pend_log.size() == 3) chk("pend_seq", {pend_log[0], pend_log[1], pend_log[2]}, 3'b110);
    // overlong message: discarded with one overflow pulse
    r0 = req_rises;
    ovf_exp++;
    for (int i = 0; i < DEPTH; i++) write_raw(8'h40, i, 1'b0);
    chk("full_ready_low", WR_READY, 0);
    write_raw(8'h40, 32'h8, 1'b1);
    repeat (10) @(negedge CLK);
    chk("ovf_pulses", ovf_seen, 1);
    chk("ovf_no_req", req_rises, r0);
    write_msg(2);
    drain("after_ovf");
    // persistent failure
    fail_mode = 1;
    t0 = tx_count;
    write_msg(2);
    drain("fail");
    chk("fail_attempts", tx_count - t0, MAX_TRIES);
    chk("fail_verdict", last_fail, 1);
    fail_mode = 2;
    // reset while in REL mid-message
    node_en = 1'b0;
    for (int i = 0; i < 3; i++) write_raw(8'h66, i, i == 2);
    wait_sig(0, 1'b1, "rst_test_req");
    man_ack = 1'b1;
    wait_sig(0, 1'b0, "rst_test_rel");
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_mid_req", TX_REQ, 0);
    chk("rst_mid_ready", WR_READY, 0);
    man_ack = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_mid_ready_after", WR_READY, 1);
    repeat (10) begin
      @(negedge CLK);
      chk("rst_mid_empty", TX_REQ, 0);
    end
    // back-to-back messages with the writer stalling on a full queue
    write_msg(5);
    write_msg(3);
    chk("ready_low_at_8", WR_READY, 0);
    node_en = 1'b1;
    write_msg(4);
    write_msg(2);
    drain("b2b");
    // randomized traffic with random verdicts and occasional overlong messages
    fail_mode = 0;
    for (int m = 0; m < 30; m++) begin
      len = ($urandom_range(0, 9) == 0) ? DEPTH + 1 + $urandom_range(0, 2) : $urandom_range(1, DEPTH);
      write_msg(len);
    end
    drain("random");
    chk("ovf_total", ovf_seen, ovf_exp);
    chk("done_q_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ulpb_tx_queue.md
# ulpb_tx_queue

Layer-side transmit queue feeding the TX port of the 32-bit ULPB bus node. It buffers complete messages from local logic and sequences them word by word over the node's four-phase TX_REQ/TX_ACK handshake, holding TX_PEND high while further words of the same message follow. It then collects the node's TX_SUCC/TX_FAIL verdict, acknowledges it with TX_RESP_ACK, and reports the outcome per message to the writer.

## Interface
- DEPTH, 8: word entries in the queue (power of two, ≥2); also the maximum message length.
- ADDR_WIDTH, `ADDR_WIDTH (8): bus address width.
- DATA_WIDTH, `DATA_WIDTH (32): bus word width.
- CLK  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- WR_VALID  in  1  writer presents a word.
- WR_READY  out  1  queue accepts the word this cycle.
- WR_ADDR  in  ADDR_WIDTH  destination address; sampled with every word, used from the first word of a message.
- WR_DATA  in  DATA_WIDTH  payload word.
- WR_LAST  in  1  final word of a message.
- MSG_DONE  out  1  one-cycle pulse: message finished.
- MSG_FAIL  out  1  qualifies MSG_DONE: 1 = failed.
- OVF_ERR  out  1  one-cycle pulse: partial message discarded.
- TX_ADDR  out  ADDR_WIDTH  to node.
- TX_DATA  out  DATA_WIDTH  to node.
- TX_PEND  out  1  more words follow the current one.
- TX_REQ  out  1  word request to node.
- TX_ACK  in  1  node ack (node clock domain).
- TX_SUCC  in  1  node success flag (node clock domain).
- TX_FAIL  in  1  node failure flag (node clock domain).
- TX_RESP_ACK  out  1  clears node success/fail flags.

## Operation
- Storage: DEPTH entries of {addr, data, last}. Pointers: wr_ptr, rd_ptr, and cmt_ptr (start of the in-flight message). Free space = DEPTH − (wr_ptr − cmt_ptr). Each pointer has one extra wrap bit.
- msg_cnt counts complete (WR_LAST-terminated) messages not yet committed. It increments on an accepted LAST word and decrements on commit.
- WR_READY = not full. Write occurs when WR_VALID & WR_READY.
- Overflow: if the queue is full and msg_cnt == 0, the message exceeds DEPTH. wr_ptr rewinds to cmt_ptr, OVF_ERR pulses, and words up to and including the next WR_LAST are accepted and dropped.
- TX_ACK, TX_SUCC and TX_FAIL each pass through a 2-flop synchronizer; the FSM uses only the synchronized versions (ack_s, succ_s, fail_s).
- FSM:
  - IDLE: when msg_cnt > 0, go to REQ.
  - REQ: TX_REQ = 1. TX_ADDR/TX_DATA come from entry rd_ptr; TX_PEND = ~last. When ack_s = 1, advance rd_ptr and go to REL.
  - REL: TX_REQ = 0. When ack_s = 0, go to REQ if the last word sent had last = 0, else to RESP.
  - RESP: wait for succ_s | fail_s. Assert TX_RESP_ACK, latch the verdict, go to RACK.
  - RACK: hold TX_RESP_ACK until succ_s = fail_s = 0, then drop it. On success: cmt_ptr ← rd_ptr, msg_cnt−1, pulse MSG_DONE with MSG_FAIL = 0, go to IDLE. On failure: see Configuration.
- TX_ADDR, TX_DATA and TX_PEND are registered. They change only in IDLE/REL, never while TX_REQ = 1.
- If succ_s and fail_s are both seen, fail takes precedence.
- Simultaneous write and commit in one cycle: both apply; msg_cnt nets correctly (+1−1).
- RESET, including mid-message: pointers, msg_cnt and synchronizers clear, FSM goes to IDLE, queue contents are lost, and no MSG_DONE is emitted.

## Timing
- Reset values: WR_READY 0 during reset (1 in the first cycle after), MSG_DONE 0, MSG_FAIL 0, OVF_ERR 0, TX_REQ 0, TX_PEND 0, TX_RESP_ACK 0, TX_ADDR 0, TX_DATA 0.
- Write of a LAST word in cycle N → TX_REQ high at N+2 (msg_cnt update at N+1, IDLE→REQ at N+2).
- TX_ACK rise → rd_ptr advance and TX_REQ fall 3 cycles later (2 sync + 1 FSM).
- Every word completes a full four-phase cycle. The next TX_REQ rises no earlier than 3 cycles after TX_ACK falls.
- MSG_DONE is exactly 1 cycle wide, in the cycle RACK exits.

## Configuration
- ULPB_TXQ_RETRY_EN defined:
  - On failure, rd_ptr ← cmt_ptr and the message is retransmitted, up to 3 retries (2-bit counter, cleared on commit).
  - MSG_DONE with MSG_FAIL = 1 pulses only after the 4th failure; the message is then committed and dropped.
- ULPB_TXQ_RETRY_EN undefined:
  - The first failure commits and drops the message and pulses MSG_DONE with MSG_FAIL = 1.
  - The retry counter is absent.

## Structure
- The shared ulpb definitions include file holds: FSM state encodings (TXQ_IDLE, TXQ_REQ, TXQ_REL, TXQ_RESP, TXQ_RACK), the retry limit constant, and the width macros.
- Sub-module ulpb_sync2: a 2-flop synchronizer with synchronous active-high reset, instantiated three times.

## Test plan
- Single-word message: addr 0x5A, data 0xDEADBEEF, LAST; node acks then TX_SUCC → TX_PEND = 0; one REQ/ACK cycle; TX_RESP_ACK high until TX_SUCC clears; MSG_DONE = 1 with MSG_FAIL = 0.
- Three-word message 0x1,0x2,0x3 → TX_PEND = 1,1,0 across the three handshakes; TX_DATA stable whenever TX_REQ = 1; no REQ issued before LAST is written.
- DEPTH = 8, 9-word message without LAST by word 8 → OVF_ERR pulse; word 9 (LAST) dropped; no TX_REQ; the next 2-word message is sent normally.
- TX_FAIL on every attempt: with RETRY_EN, 4 transmissions then MSG_DONE with MSG_FAIL = 1; without it, 1 transmission then MSG_DONE with MSG_FAIL = 1.
- RESET asserted while in REL mid-message → TX_REQ = 0 the next cycle; queue empty; WR_READY = 1; no MSG_DONE.
- Back-to-back messages written while the first is in flight; writer stalls when full → both delivered in order; WR_READY deasserts at 8 occupied entries.
